bus_master_mux_pipe: RTL and testbench



---
 rtl/bus_pkg.sv | 35 +++
 rtl/bus_master_mux_pipe_if.sv | 45 ++++
 rtl/bus_pipe_reg.sv | 37 +++
 rtl/bus_master_mux_pipe.sv | 141 ++++++++++++++
 tb/tb_bus_master_mux_pipe.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and helpers for the master-side bus multiplexer.
// Grant vectors are zero-extended to MAX_MASTERS bits before they reach the helpers.
package bus_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_BURST_W = 12;
  localparam int MAX_MASTERS = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic logic is_onehot(input logic [MAX_MASTERS-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      cnt += int'(vec[i]);
    end
    return (cnt == 1);
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_MASTERS-1:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (vec[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_master_mux_pipe_if.sv
// Bundle of the arbiter, master-side and slave-side signals of the multiplexer.
// The slave modport is the multiplexer's view; the master modport is its environment.
interface bus_master_mux_pipe_if
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BURST_W     = DEF_BURST_W
) ();

  localparam int OW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]         bus_grant;
  logic [NUM_MASTERS-1:0]         m_valid;
  logic [NUM_MASTERS-1:0]         m_read_en;
  logic [NUM_MASTERS-1:0]         m_write_en;
  logic [NUM_MASTERS*ADDR_W-1:0]  m_addr;
  logic [NUM_MASTERS*DATA_W-1:0]  m_data;
  logic [NUM_MASTERS*BURST_W-1:0] m_burst;
  logic [NUM_MASTERS-1:0]         m_ready;
  logic                           s_valid;
  logic                           s_read_en;
  logic                           s_write_en;
  logic [ADDR_W-1:0]              s_addr;
  logic [DATA_W-1:0]              s_data;
  logic [BURST_W-1:0]             s_burst;
  logic                           s_ready;
  logic                           locked;
  logic [OW-1:0]                  owner;
  logic                           grant_error;

  modport master (
    output bus_grant, m_valid, m_read_en, m_write_en, m_addr, m_data, m_burst, s_ready,
    input  m_ready, s_valid, s_read_en, s_write_en, s_addr, s_data, s_burst,
           locked, owner, grant_error
  );

  modport slave (
    input  bus_grant, m_valid, m_read_en, m_write_en, m_addr, m_data, m_burst, s_ready,
    output m_ready, s_valid, s_read_en, s_write_en, s_addr, s_data, s_burst,
           locked, owner, grant_error
  );

endinterface

// File: rtl/bus_pipe_reg.sv
// Single-stage valid/ready register: loads whenever it is empty or being drained,
// so it sustains one beat per cycle while the consumer keeps ready high.
module bus_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             load;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign load        = in_valid_i && in_ready_o;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bus_master_mux_pipe.sv
// Master-side bus multiplexer: decodes a one-hot grant, forwards the chosen master
// through one register stage and freezes the owner for the length of a burst.
module bus_master_mux_pipe
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BURST_W     = DEF_BURST_W
) (
  input logic                clk,
  input logic                rst,
  bus_master_mux_pipe_if.slave bus
);

  localparam int OW = $clog2(NUM_MASTERS);
  localparam int PW = 2 + ADDR_W + DATA_W + BURST_W;

  state_e                   state_q, state_d;
  logic [OW-1:0]            owner_q, owner_d;
  logic [BURST_W-1:0]       remain_q, remain_d;
  logic [BURST_W-1:0]       latched_q, latched_d;
  logic                     gErr_q, gErr_d;

  logic [MAX_MASTERS-1:0]   grantWide;
  logic                     grantOk;
  logic [OW-1:0]            selIdx;
  logic                     selValid;
  logic                     reqValid;
  logic                     canLoad;
  logic                     accept;
  logic                     sValid;
  logic                     selRd;
  logic                     selWr;
  logic [ADDR_W-1:0]        selAddr;
  logic [DATA_W-1:0]        selData;
  logic [BURST_W-1:0]       selBurst;
  logic [BURST_W-1:0]       effBurst;
  logic [BURST_W-1:0]       outBurst;
  logic [NUM_MASTERS-1:0]   mReady;
  logic [PW-1:0]            payloadIn;
  logic [PW-1:0]            payloadOut;

  assign grantWide = MAX_MASTERS'(bus.bus_grant);
  assign grantOk   = is_onehot(grantWide);

  // While a burst is in flight the owner register overrides whatever the arbiter says.
  always_comb begin
    selValid = 1'b0;
    selIdx   = '0;
    if (state_q == LOCKED) begin
      selValid = 1'b1;
      selIdx   = owner_q;
    end else if (grantOk) begin
      selValid = 1'b1;
      selIdx   = OW'(onehot_to_idx(grantWide));
    end
  end

  assign selRd    = bus.m_read_en[selIdx];
  assign selWr    = bus.m_write_en[selIdx];
  assign selAddr  = bus.m_addr[selIdx*ADDR_W +: ADDR_W];
  assign selData  = bus.m_data[selIdx*DATA_W +: DATA_W];
  assign selBurst = bus.m_burst[selIdx*BURST_W +: BURST_W];
  assign effBurst = (selBurst == '0) ? BURST_W'(1) : selBurst;
  assign outBurst = (state_q == LOCKED) ? latched_q : selBurst;

  assign reqValid = selValid && bus.m_valid[selIdx];
  assign accept   = reqValid && canLoad;

  // Ready is offered to the selected master independent of its valid.
  always_comb begin
    mReady = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      mReady[i] = selValid && canLoad && (selIdx == OW'(i));
    end
  end

  assign payloadIn = {selRd, selWr, selAddr, selData, outBurst};

  bus_pipe_reg #(
    .WIDTH(PW)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (reqValid),
    .in_ready_o (canLoad),
    .in_data_i  (payloadIn),
    .out_valid_o(sValid),
    .out_ready_i(bus.s_ready),
    .out_data_o (payloadOut)
  );

  // The final beat of a burst releases the lock on the same edge that accepts it.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    remain_d  = remain_q;
    latched_d = latched_q;
    gErr_d    = (state_q == IDLE) && !grantOk && (|bus.m_valid);
    if (accept) begin
      if (state_q == IDLE) begin
        owner_d = selIdx;
        if ((selRd || selWr) && (effBurst > BURST_W'(1))) begin
          state_d   = LOCKED;
          remain_d  = effBurst - BURST_W'(1);
          latched_d = selBurst;
        end
      end else begin
        remain_d = remain_q - BURST_W'(1);
        if (remain_q == BURST_W'(1)) begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      remain_q  <= '0;
      latched_q <= '0;
      gErr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      remain_q  <= remain_d;
      latched_q <= latched_d;
      gErr_q    <= gErr_d;
    end
  end

  assign bus.m_ready = mReady;
  assign bus.s_valid = sValid;
  assign {bus.s_read_en, bus.s_write_en, bus.s_addr, bus.s_data, bus.s_burst} = payloadOut;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.owner       = owner_q;
  assign bus.grant_error = gErr_q;

endmodule

// File: tb/tb_bus_master_mux_pipe.sv
// Scenario bench for bus_master_mux_pipe with four masters, plus a randomized run
// compared against a transaction-level model of the selection and burst rules.
module tb_bus_master_mux_pipe;

  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int BW = 12;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  bus_master_mux_pipe_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) busIf ();

  bus_master_mux_pipe #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: registered slave word, lock owner and beats still owed.
  bit          mSValid, mRd, mWr, mLocked, mGErr;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;
  logic [BW-1:0] mBurst, mLatched;
  int          mOwner, mLeft;

  task automatic modelReset();
    mSValid = 0; mRd = 0; mWr = 0; mLocked = 0; mGErr = 0;
    mAddr = '0; mData = '0; mBurst = '0; mLatched = '0;
    mOwner = 0; mLeft = 0;
  endtask

  function automatic int modelSel(output bit ok);
    int cnt = 0;
    int idx = 0;
    if (mLocked) begin
      ok = 1'b1;
      return mOwner;
    end
    for (int i = 0; i < NM; i++) begin
      if (busIf.bus_grant[i]) begin
        cnt++;
        idx = i;
      end
    end
    ok = (cnt == 1);
    return ok ? idx : 0;
  endfunction

  function automatic logic [NM-1:0] modelReady();
    bit ok;
    int sel;
    logic [NM-1:0] r = '0;
    sel = modelSel(ok);
    if (ok && (!mSValid || busIf.s_ready)) r[sel] = 1'b1;
    return r;
  endfunction

  task automatic modelStep();
    bit ok, acc;
    int sel, eff;
    logic [NM-1:0] rdy;
    logic [BW-1:0] b;
    if (rst) begin
      modelReset();
      return;
    end
    sel = modelSel(ok);
    rdy = modelReady();
    acc = ok && rdy[sel] && busIf.m_valid[sel];
    mGErr = !mLocked && !ok && (busIf.m_valid != '0);
    if (acc) begin
      b       = busIf.m_burst[sel*BW +: BW];
      mRd     = busIf.m_read_en[sel];
      mWr     = busIf.m_write_en[sel];
      mAddr   = busIf.m_addr[sel*AW +: AW];
      mData   = busIf.m_data[sel*DW +: DW];
      mSValid = 1'b1;
      if (mLocked) begin
        mBurst = mLatched;
        mLeft--;
        if (mLeft == 0) mLocked = 1'b0;
      end else begin
        mBurst = b;
        mOwner = sel;
        eff = (b == '0) ? 1 : int'(b);
        if ((mRd || mWr) && eff > 1) begin
          mLocked  = 1'b1;
          mLeft    = eff - 1;
          mLatched = b;
        end
      end
    end else if (busIf.s_ready) begin
      mSValid = 1'b0;
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic setMaster(input int idx, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [BW-1:0] b);
    busIf.m_read_en[idx]       = rd;
    busIf.m_write_en[idx]      = wr;
    busIf.m_addr[idx*AW +: AW] = a;
    busIf.m_data[idx*DW +: DW] = d;
    busIf.m_burst[idx*BW +: BW] = b;
  endtask

  task automatic applyStimulus(input logic [NM-1:0] grant, input logic [NM-1:0] valid,
                               input bit sReady);
    busIf.bus_grant = grant;
    busIf.m_valid   = valid;
    busIf.s_ready   = sReady;
  endtask

  task automatic clearInputs();
    applyStimulus('0, '0, 1'b1);
    busIf.m_read_en  = '0;
    busIf.m_write_en = '0;
    busIf.m_addr     = '0;
    busIf.m_data     = '0;
    busIf.m_burst    = '0;
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busIf.s_valid, busIf.locked, busIf.owner, busIf.grant_error} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got valid=%0b locked=%0b owner=%0d gerr=%0b exp all 0",
               busIf.s_valid, busIf.locked, busIf.owner, busIf.grant_error);
    end
    checks++;
    if ({busIf.s_addr, busIf.s_data, busIf.s_burst} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got addr=%h data=%h burst=%h exp 0",
               busIf.s_addr, busIf.s_data, busIf.s_burst);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    clearInputs();
    applyStimulus(4'b0001, 4'b0001, 1'b1);
    setMaster(0, 1'b0, 1'b1, 16'h0040, 8'hA5, 12'd1);
    #1;
    checks++;
    if (busIf.m_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_m_ready got=%b exp=0001", busIf.m_ready);
    end
    tick();
    checks++;
    if ({busIf.s_valid, busIf.s_addr, busIf.s_data, busIf.locked} !== {1'b1, 16'h0040, 8'hA5, 1'b0}) begin
      errors++;
      $display("[TB] FAIL single_out got valid=%0b addr=%h data=%h locked=%0b exp 1/0040/a5/0",
               busIf.s_valid, busIf.s_addr, busIf.s_data, busIf.locked);
    end
    busIf.m_valid = '0;
    tick();
    checks++;
    if (busIf.s_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_drain got s_valid=%0b exp=0", busIf.s_valid);
    end
  endtask

  task automatic test_burst_lock();
    clearInputs();
    applyStimulus(4'b0010, 4'b0010, 1'b1);
    setMaster(1, 1'b1, 1'b0, 16'h0100, 8'h10, 12'd4);
    tick();
    checks++;
    if ({busIf.locked, busIf.owner, busIf.s_addr, busIf.s_burst} !== {1'b1, 2'd1, 16'h0100, 12'd4}) begin
      errors++;
      $display("[TB] FAIL lock_first got locked=%0b owner=%0d addr=%h burst=%0d exp 1/1/0100/4",
               busIf.locked, busIf.owner, busIf.s_addr, busIf.s_burst);
    end
    for (int k = 1; k < 4; k++) begin
      applyStimulus(4'b0001, 4'b0011, 1'b1);
      setMaster(0, 1'b1, 1'b0, 16'hBEEF, 8'hEE, 12'd1);
      setMaster(1, 1'b1, 1'b0, AW'(16'h0100 + k), DW'(8'h10 + k), 12'd9);
      #1;
      checks++;
      if (busIf.m_ready !== 4'b0010) begin
        errors++;
        $display("[TB] FAIL lock_m_ready beat=%0d got=%b exp=0010", k, busIf.m_ready);
      end
      tick();
      checks++;
      if ({busIf.s_addr, busIf.s_data, busIf.s_burst, busIf.owner, busIf.locked} !==
          {AW'(16'h0100 + k), DW'(8'h10 + k), 12'd4, 2'd1, (k < 3) ? 1'b1 : 1'b0}) begin
        errors++;
        $display("[TB] FAIL lock_beat beat=%0d got addr=%h data=%h burst=%0d owner=%0d locked=%0b",
                 k, busIf.s_addr, busIf.s_data, busIf.s_burst, busIf.owner, busIf.locked);
      end
    end
    clearInputs();
    tick();
  endtask

  task automatic test_backpressure();
    clearInputs();
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    setMaster(2, 1'b0, 1'b1, 16'h0200, 8'h20, 12'd5);
    tick();
    busIf.s_ready = 1'b0;
    setMaster(2, 1'b0, 1'b1, 16'h0201, 8'h21, 12'd5);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (busIf.m_ready !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL stall_m_ready cycle=%0d got=%b exp=0000", c, busIf.m_ready);
      end
      tick();
      checks++;
      if ({busIf.s_valid, busIf.s_addr, busIf.s_data, busIf.locked} !== {1'b1, 16'h0200, 8'h20, 1'b1}) begin
        errors++;
        $display("[TB] FAIL stall_hold cycle=%0d got valid=%0b addr=%h data=%h locked=%0b",
                 c, busIf.s_valid, busIf.s_addr, busIf.s_data, busIf.locked);
      end
    end
    busIf.s_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      setMaster(2, 1'b0, 1'b1, AW'(16'h0200 + k), DW'(8'h20 + k), 12'd5);
      tick();
      checks++;
      if ({busIf.s_valid, busIf.s_addr, busIf.locked} !== {1'b1, AW'(16'h0200 + k), (k < 4) ? 1'b1 : 1'b0}) begin
        errors++;
        $display("[TB] FAIL resume beat=%0d got valid=%0b addr=%h locked=%0b",
                 k, busIf.s_valid, busIf.s_addr, busIf.locked);
      end
    end
    clearInputs();
    tick();
  endtask

  task automatic test_illegal_grant();
    clearInputs();
    applyStimulus(4'b0011, 4'b0011, 1'b1);
    setMaster(0, 1'b1, 1'b0, 16'h0A00, 8'h0A, 12'd1);
    setMaster(1, 1'b1, 1'b0, 16'h0B00, 8'h0B, 12'd1);
    #1;
    checks++;
    if (busIf.m_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL multihot_m_ready got=%b exp=0000", busIf.m_ready);
    end
    tick();
    checks++;
    if ({busIf.s_valid, busIf.grant_error, busIf.locked} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL multihot_err got valid=%0b gerr=%0b locked=%0b exp 0/1/0",
               busIf.s_valid, busIf.grant_error, busIf.locked);
    end
    applyStimulus(4'b0000, 4'b0001, 1'b1);
    #1;
    checks++;
    if (busIf.m_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL nogrant_m_ready got=%b exp=0000", busIf.m_ready);
    end
    tick();
    checks++;
    if ({busIf.s_valid, busIf.grant_error} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL nogrant_err got valid=%0b gerr=%0b exp 0/1", busIf.s_valid, busIf.grant_error);
    end
    busIf.m_valid = '0;
    tick();
    checks++;
    if (busIf.grant_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear got gerr=%0b exp=0", busIf.grant_error);
    end
  endtask

  task automatic test_reset_mid_burst();
    clearInputs();
    applyStimulus(4'b0010, 4'b0010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      setMaster(1, 1'b1, 1'b0, AW'(16'h0300 + k), DW'(8'h30 + k), 12'd8);
      tick();
    end
    checks++;
    if (busIf.locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midburst_locked got=%0b exp=1", busIf.locked);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busIf.s_valid, busIf.locked, busIf.owner, busIf.grant_error} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL midburst_reset got valid=%0b locked=%0b owner=%0d gerr=%0b exp all 0",
               busIf.s_valid, busIf.locked, busIf.owner, busIf.grant_error);
    end
    clearInputs();
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    setMaster(2, 1'b1, 1'b0, 16'h0400, 8'h44, 12'd1);
    #1;
    checks++;
    if (busIf.m_ready !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL post_reset_m_ready got=%b exp=0100", busIf.m_ready);
    end
    tick();
    checks++;
    if ({busIf.s_valid, busIf.s_addr, busIf.owner, busIf.locked} !== {1'b1, 16'h0400, 2'd2, 1'b0}) begin
      errors++;
      $display("[TB] FAIL post_reset_beat got valid=%0b addr=%h owner=%0d locked=%0b exp 1/0400/2/0",
               busIf.s_valid, busIf.s_addr, busIf.owner, busIf.locked);
    end
    clearInputs();
    tick();
  endtask

  task automatic test_burst_zero();
    clearInputs();
    applyStimulus(4'b1000, 4'b1000, 1'b1);
    setMaster(3, 1'b0, 1'b1, 16'h0500, 8'h55, 12'd0);
    tick();
    checks++;
    if ({busIf.s_valid, busIf.owner, busIf.locked, busIf.s_burst} !== {1'b1, 2'd3, 1'b0, 12'd0}) begin
      errors++;
      $display("[TB] FAIL burst0 got valid=%0b owner=%0d locked=%0b burst=%0d exp 1/3/0/0",
               busIf.s_valid, busIf.owner, busIf.locked, busIf.s_burst);
    end
    setMaster(3, 1'b0, 1'b1, 16'h0501, 8'h56, 12'd0);
    #1;
    checks++;
    if (busIf.m_ready !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL burst0_again_m_ready got=%b exp=1000", busIf.m_ready);
    end
    tick();
    checks++;
    if ({busIf.s_addr, busIf.locked} !== {16'h0501, 1'b0}) begin
      errors++;
      $display("[TB] FAIL burst0_again got addr=%h locked=%0b exp 0501/0", busIf.s_addr, busIf.locked);
    end
    clearInputs();
    tick();
  endtask

  task automatic test_random();
    int gsel;
    logic [NM-1:0] expReady;
    for (int i = 0; i < 400; i++) begin
      gsel = $urandom_range(0, 9);
      if (gsel < 8)       busIf.bus_grant = NM'(1) << (gsel % NM);
      else if (gsel == 8) busIf.bus_grant = '0;
      else                busIf.bus_grant = NM'($urandom_range(0, 15));
      busIf.m_valid = NM'($urandom);
      busIf.s_ready = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < NM; j++) begin
        setMaster(j, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), BW'($urandom_range(0, 5)));
      end
      rst = ($urandom_range(0, 99) == 0);
      #1;
      expReady = modelReady();
      checks++;
      if (busIf.m_ready !== expReady) begin
        errors++;
        $display("[TB] FAIL rand_m_ready cycle=%0d got=%b exp=%b", i, busIf.m_ready, expReady);
      end
      tick();
      rst = 1'b0;
      checks++;
      if ({busIf.s_valid, busIf.s_read_en, busIf.s_write_en, busIf.s_addr, busIf.s_data,
           busIf.s_burst, busIf.locked, busIf.owner, busIf.grant_error} !==
          {mSValid, mRd, mWr, mAddr, mData, mBurst, mLocked, 2'(mOwner), mGErr}) begin
        errors++;
        $display("[TB] FAIL rand_out cycle=%0d got v=%0b r=%0b w=%0b a=%h d=%h b=%0d l=%0b o=%0d e=%0b exp v=%0b r=%0b w=%0b a=%h d=%h b=%0d l=%0b o=%0d e=%0b",
                 i, busIf.s_valid, busIf.s_read_en, busIf.s_write_en, busIf.s_addr, busIf.s_data,
                 busIf.s_burst, busIf.locked, busIf.owner, busIf.grant_error,
                 mSValid, mRd, mWr, mAddr, mData, mBurst, mLocked, mOwner, mGErr);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    modelReset();
    test_reset();
    test_single_beat();
    test_burst_lock();
    test_backpressure();
    test_illegal_grant();
    test_reset_mid_burst();
    test_burst_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
